// File: rtl/universal_reg_nb.sv
// Parametrised N-bit register with mode-selected next state (hold, load, shift,
// rotate, increment, decrement, clear), serial-out, wrap pulse and zero flag.
module universal_reg_nb #(
  parameter int unsigned     WIDTH       = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             SerIn,
  output logic [WIDTH-1:0] out,
  output logic             SerOut,
  output logic             Wrap,
  output logic             Zero
);

  localparam int unsigned EXT_W = WIDTH + 1;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_INC  = 3'b100,
    MODE_DEC  = 3'b101,
    MODE_ROL  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  if (WIDTH < 2) begin : g_bad_width
    $error("universal_reg_nb: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             ser_q, ser_d;
  logic             wrap_q, wrap_d;
  logic [EXT_W-1:0] inc_ext, dec_ext;
  mode_e            mode;

  assign mode = mode_e'(Mode);

  // Extended-width sum/difference: the extra MSB is the carry/borrow that drives Wrap
  assign inc_ext = {1'b0, out_q} + EXT_W'(1);
  assign dec_ext = {1'b0, out_q} - EXT_W'(1);

  // Next-state selection; wrap is a single-cycle pulse so it defaults low
  always_comb begin
    out_d  = out_q;
    ser_d  = ser_q;
    wrap_d = 1'b0;
    if (En) begin
      case (mode)
        MODE_HOLD: begin
          out_d = out_q;
        end
        MODE_LOAD: begin
          out_d = DataIn;
        end
        MODE_SHL: begin
          out_d = {out_q[WIDTH-2:0], SerIn};
          ser_d = out_q[WIDTH-1];
        end
        MODE_SHR: begin
          out_d = {SerIn, out_q[WIDTH-1:1]};
          ser_d = out_q[0];
        end
        MODE_INC: begin
          out_d  = inc_ext[WIDTH-1:0];
          wrap_d = inc_ext[WIDTH];
        end
        MODE_DEC: begin
          out_d  = dec_ext[WIDTH-1:0];
          wrap_d = dec_ext[WIDTH];
        end
        MODE_ROL: begin
          out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
          ser_d = out_q[WIDTH-1];
        end
        MODE_CLR: begin
          out_d = '0;
        end
        default: begin
          out_d = out_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= RESET_VALUE;
      ser_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      ser_q  <= ser_d;
      wrap_q <= wrap_d;
    end
  end

  assign out    = out_q;
  assign SerOut = ser_q;
  assign Wrap   = wrap_q;
  assign Zero   = (out_q == '0);

endmodule

// File: tb/tb_universal_reg_nb.sv
// Bench for universal_reg_nb: three widths (5, 2, 16) driven in lockstep and
// checked every cycle against an arithmetic model, plus literal expectations.
module tb_universal_reg_nb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  mode;
  logic [15:0] din;
  logic        ser_in;

  logic [4:0]  out5;
  logic [1:0]  out2;
  logic [15:0] out16;
  logic        so5, so2, so16;
  logic        wr5, wr2, wr16;
  logic        z5, z2, z16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  universal_reg_nb #(.WIDTH(5), .RESET_VALUE(5'h0A)) u_w5 (
    .clk(clk), .rst_n(rst_n), .En(en), .Mode(mode), .DataIn(din[4:0]),
    .SerIn(ser_in), .out(out5), .SerOut(so5), .Wrap(wr5), .Zero(z5));

  universal_reg_nb #(.WIDTH(2), .RESET_VALUE(2'b10)) u_w2 (
    .clk(clk), .rst_n(rst_n), .En(en), .Mode(mode), .DataIn(din[1:0]),
    .SerIn(ser_in), .out(out2), .SerOut(so2), .Wrap(wr2), .Zero(z2));

  universal_reg_nb #(.WIDTH(16), .RESET_VALUE(16'h00A5)) u_w16 (
    .clk(clk), .rst_n(rst_n), .En(en), .Mode(mode), .DataIn(din),
    .SerIn(ser_in), .out(out16), .SerOut(so16), .Wrap(wr16), .Zero(z16));

  // Model state per instance: widths, reset values, contents, serial bit, wrap
  int          w  [3] = '{5, 2, 16};
  logic [15:0] rv [3] = '{16'h000A, 16'h0002, 16'h00A5};
  logic [15:0] m_val [3];
  logic        m_ser [3];
  logic        m_wrap[3];
  bit          model_valid = 1'b0;

  function automatic logic [15:0] mask_of(int width);
    return (width >= 16) ? 16'hFFFF : 16'((32'd1 << width) - 1);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: each mode expressed as plain unsigned arithmetic on the value
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [15:0] m;
      logic [15:0] v;
      logic        msb;
      m   = mask_of(w[i]);
      v   = m_val[i];
      msb = v[w[i]-1];
      m_wrap[i] = 1'b0;
      if (!rst_n) begin
        m_val[i] = rv[i];
        m_ser[i] = 1'b0;
      end else if (en) begin
        case (mode)
          3'd1: m_val[i] = din & m;
          3'd2: begin m_val[i] = ((v * 2) + 16'(ser_in)) & m; m_ser[i] = msb; end
          3'd3: begin
            m_val[i] = (v / 2) + (ser_in ? 16'((32'd1 << (w[i] - 1))) : 16'd0);
            m_ser[i] = v[0];
          end
          3'd4: begin m_wrap[i] = (v == m); m_val[i] = (v + 16'd1) & m; end
          3'd5: begin m_wrap[i] = (v == 16'd0); m_val[i] = (v - 16'd1) & m; end
          3'd6: begin m_val[i] = ((v * 2) + 16'(msb)) & m; m_ser[i] = msb; end
          3'd7: m_val[i] = 16'd0;
          default: ;
        endcase
      end
    end
    if (!rst_n) model_valid <= 1'b1;
  end

  // Compare process: every instance, every cycle after the first reset edge
  always @(negedge clk) begin
    if (model_valid) begin
      chk("w5_out",   16'(out5),  m_val[0]);
      chk("w5_ser",   16'(so5),   16'(m_ser[0]));
      chk("w5_wrap",  16'(wr5),   16'(m_wrap[0]));
      chk("w5_zero",  16'(z5),    16'(m_val[0] == 16'd0));
      chk("w2_out",   16'(out2),  m_val[1]);
      chk("w2_ser",   16'(so2),   16'(m_ser[1]));
      chk("w2_wrap",  16'(wr2),   16'(m_wrap[1]));
      chk("w2_zero",  16'(z2),    16'(m_val[1] == 16'd0));
      chk("w16_out",  out16,      m_val[2]);
      chk("w16_ser",  16'(so16),  16'(m_ser[2]));
      chk("w16_wrap", 16'(wr16),  16'(m_wrap[2]));
      chk("w16_zero", 16'(z16),   16'(m_val[2] == 16'd0));
    end
  end

  task automatic step(input logic r, input logic e, input logic [2:0] md,
                      input logic [15:0] d, input logic s);
    @(negedge clk);
    rst_n = r; en = e; mode = md; din = d; ser_in = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 3'd0; din = 16'd0; ser_in = 1'b0;

    // Reset and load
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    chk("rst_out5", 16'(out5), 16'h000A);
    chk("rst_ser5", 16'(so5), 16'h0);
    chk("rst_wrap5", 16'(wr5), 16'h0);
    chk("rst_zero5", 16'(z5), 16'h0);
    chk("rst_out16", out16, 16'h00A5);
    step(1'b1, 1'b1, 3'd1, 16'h0013, 1'b0);
    chk("load_out5", 16'(out5), 16'h0013);
    step(1'b1, 1'b0, 3'd1, 16'h001F, 1'b0);
    chk("en0_hold5", 16'(out5), 16'h0013);

    // Increment wrap on all widths: load all-ones minus one
    step(1'b1, 1'b1, 3'd1, 16'hFFFE, 1'b0);
    step(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0);
    chk("inc1_out5", 16'(out5), 16'h001F);
    chk("inc1_wrap5", 16'(wr5), 16'h0);
    chk("inc1_out2", 16'(out2), 16'h0003);
    chk("inc1_out16", out16, 16'hFFFF);
    step(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0);
    chk("inc2_out5", 16'(out5), 16'h0000);
    chk("inc2_wrap5", 16'(wr5), 16'h1);
    chk("inc2_zero5", 16'(z5), 16'h1);
    chk("inc2_wrap2", 16'(wr2), 16'h1);
    chk("inc2_wrap16", 16'(wr16), 16'h1);
    step(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0);
    chk("inc3_out5", 16'(out5), 16'h0001);
    chk("inc3_wrap5", 16'(wr5), 16'h0);
    chk("inc3_zero5", 16'(z5), 16'h0);

    // Decrement wrap after clear
    step(1'b1, 1'b1, 3'd7, 16'h0000, 1'b0);
    chk("clr_out5", 16'(out5), 16'h0000);
    chk("clr_zero5", 16'(z5), 16'h1);
    step(1'b1, 1'b1, 3'd5, 16'h0000, 1'b0);
    chk("dec_out5", 16'(out5), 16'h001F);
    chk("dec_wrap5", 16'(wr5), 16'h1);
    chk("dec_out16", out16, 16'hFFFF);
    step(1'b1, 1'b1, 3'd0, 16'h0000, 1'b0);
    chk("dec_wrap_gone5", 16'(wr5), 16'h0);

    // Shift and rotate
    step(1'b1, 1'b1, 3'd1, 16'h0011, 1'b0);
    step(1'b1, 1'b1, 3'd2, 16'h0000, 1'b0);
    chk("shl_out5", 16'(out5), 16'h0002);
    chk("shl_ser5", 16'(so5), 16'h1);
    chk("shl_out16", out16, 16'h0022);
    step(1'b1, 1'b1, 3'd3, 16'h0000, 1'b1);
    chk("shr_out5", 16'(out5), 16'h0011);
    chk("shr_ser5", 16'(so5), 16'h0);
    chk("shr_out16", out16, 16'h8011);
    step(1'b1, 1'b1, 3'd6, 16'h0000, 1'b0);
    chk("rol_out5", 16'(out5), 16'h0003);
    chk("rol_ser5", 16'(so5), 16'h1);
    step(1'b1, 1'b1, 3'd0, 16'h0000, 1'b0);
    chk("hold_ser5", 16'(so5), 16'h1);
    step(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0);
    chk("inc_keeps_ser5", 16'(so5), 16'h1);

    // Mid-operation reset
    step(1'b1, 1'b1, 3'd1, 16'h0005, 1'b0);
    step(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0);
    chk("mid1_out5", 16'(out5), 16'h0006);
    step(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0);
    chk("mid2_out5", 16'(out5), 16'h0007);
    step(1'b0, 1'b1, 3'd4, 16'h0000, 1'b0);
    chk("mid3_out5", 16'(out5), 16'h000A);
    chk("mid3_ser5", 16'(so5), 16'h0);
    step(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0);
    chk("mid4_out5", 16'(out5), 16'h000B);

    // Reset beats a wrapping increment at the same edge
    step(1'b1, 1'b1, 3'd1, 16'hFFFF, 1'b0);
    step(1'b0, 1'b1, 3'd4, 16'h0000, 1'b0);
    chk("rst_vs_wrap5", 16'(wr5), 16'h0);
    chk("rst_vs_out2", 16'(out2), 16'h0002);

    // Short mixed sequence for broad model coverage
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'(k % 5 != 0), 3'(k * 3), 16'((k * 16'h1357) ^ 16'hA5C3), 1'(k & 1));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
